star_data_server: RTL and testbench

Input-side responder for the STAR softmax core. It is preloaded with one 256-byte input vector over a simple valid/ready load port. It then answers the core's `data_req`/`data_addr` read requests with registered one-cycle-latency data until the core raises `finish`. It replaces behavioural testbench data feeding with synthesizable RTL that sits between the host/DMA side and `STAR`.

---
 rtl/star_data_server.sv | 134 +++++++++++++
 tb/tb_star_data_server.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/star_data_server.sv
// Input-side data responder for the STAR softmax core: preload DEPTH bytes over a
// valid/ready port, then answer one-cycle-latency read requests until finish.
module star_data_server #(
   parameter int DEPTH = 256,
   parameter int AW    = 9,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_valid,
   input  logic [DW-1:0] load_data,
   output logic          load_ready,
   output logic          load_done,
   input  logic          data_req,
   input  logic [AW-1:0] data_addr,
   output logic [DW-1:0] data,
   output logic          data_valid,
   input  logic          finish,
   output logic          addr_err,
   output logic [15:0]   req_count
);

   localparam int IW = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SERVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [DW-1:0] data_q, data_d;
   logic          data_valid_q, data_valid_d;
   logic          addr_err_q, addr_err_d;
   logic [15:0]   req_count_q, req_count_d;
   logic          mem_we_s;
   logic          in_range_s;
   logic [DW-1:0] mem_q [DEPTH];

   // DEPTH is a power of two, so in-range means all bits above the index are zero
   assign in_range_s = (data_addr[AW-1:IW] == {(AW-IW){1'b0}});

   // Next-state, write-enable and response computation
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      data_d       = {DW{1'b0}};
      data_valid_d = 1'b0;
      addr_err_d   = addr_err_q;
      req_count_d  = req_count_q;
      mem_we_s     = 1'b0;
      case (state_q)
         LOAD: begin
            if (load_valid) begin
               mem_we_s = 1'b1;
               wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
               if (wr_ptr_q == LAST_PTR) begin
                  state_d = SERVE;
               end else begin
                  state_d = LOAD;
               end
            end else begin
               mem_we_s = 1'b0;
            end
         end
         SERVE: begin
            if (data_req) begin
               data_valid_d = 1'b1;
               if (in_range_s) begin
                  data_d = mem_q[data_addr[IW-1:0]];
               end else begin
                  data_d     = {DW{1'b0}};
                  addr_err_d = 1'b1;
               end
               if (req_count_q != 16'hFFFF) begin
                  req_count_d = req_count_q + 16'd1;
               end else begin
                  req_count_d = req_count_q;
               end
            end else begin
               data_valid_d = 1'b0;
            end
            // A request coinciding with finish is still answered above
            if (finish) begin
               state_d = DONE;
            end else begin
               state_d = SERVE;
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= LOAD;
         wr_ptr_q     <= {AW{1'b0}};
         data_q       <= {DW{1'b0}};
         data_valid_q <= 1'b0;
         addr_err_q   <= 1'b0;
         req_count_q  <= 16'd0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         data_q       <= data_d;
         data_valid_q <= data_valid_d;
         addr_err_q   <= addr_err_d;
         req_count_q  <= req_count_d;
      end
   end

   // Byte storage; deliberately not cleared by reset
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[wr_ptr_q[IW-1:0]] <= load_data;
      end
   end

   assign load_ready = (state_q == LOAD);
   assign load_done  = (state_q != LOAD);
   assign data       = data_q;
   assign data_valid = data_valid_q;
   assign addr_err   = addr_err_q;
   assign req_count  = req_count_q;

endmodule

// File: tb/tb_star_data_server.sv
// Directed self-checking bench for star_data_server.
module tb_star_data_server;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_valid;
   logic [7:0]  load_data;
   logic        load_ready;
   logic        load_done;
   logic        data_req;
   logic [8:0]  data_addr;
   logic [7:0]  data;
   logic        data_valid;
   logic        finish;
   logic        addr_err;
   logic [15:0] req_count;

   int tests_run = 0;
   int fails = 0;

   star_data_server #(.DEPTH(256), .AW(9), .DW(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .load_done  (load_done),
      .data_req   (data_req),
      .data_addr  (data_addr),
      .data       (data),
      .data_valid (data_valid),
      .finish     (finish),
      .addr_err   (addr_err),
      .req_count  (req_count)
   );

   always #5 clk = ~clk;

   // Byte pattern for each load scenario
   function automatic logic [7:0] pat(input int mode, input int i);
      logic [7:0] b;
      b = i[7:0];
      if (mode == 0)      return b ^ 8'hA5;
      else if (mode == 1) return (b * 8'd3) + 8'h11;
      else                return b ^ 8'h3C;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Load all bytes; counts accepted edges and any protocol anomalies seen
   task automatic do_load(input int mode, input bit rnd, output int acc, output int bad);
      int cyc;
      acc = 0; bad = 0; cyc = 0;
      while (load_ready && cyc < 2000) begin
         load_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         load_data  = pat(mode, acc);
         data_req   = rnd;
         data_addr  = acc[8:0];
         if (load_done) bad++;
         if (load_valid) acc++;
         step();
         if (data_valid) bad++;
         cyc++;
      end
      load_valid = 1'b0;
      data_req   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; load_valid = 1'b0; load_data = 8'h00;
      data_req = 1'b0; data_addr = 9'd0; finish = 1'b0;
      step(); step();
      tests_run++;
      if ({load_ready, load_done, data_valid, addr_err} !== 4'b1000 || data !== 8'h00 || req_count !== 16'd0) begin
         fails++;
         $display("FAIL reset_state: rdy/done/vld/err=%b data=%h cnt=%0d, need 1000 00 0",
                  {load_ready, load_done, data_valid, addr_err}, data, req_count);
      end
      reset = 1'b1;
   endtask

   task automatic test_load();
      int acc, bad;
      do_load(0, 1'b0, acc, bad);
      tests_run++;
      if (acc !== 256 || bad !== 0) begin
         fails++;
         $display("FAIL load_count: accepted=%0d anomalies=%0d, need 256 0", acc, bad);
      end
      tests_run++;
      if (load_done !== 1'b1 || load_ready !== 1'b0) begin
         fails++;
         $display("FAIL load_done: done=%b ready=%b, need 1 0", load_done, load_ready);
      end
   endtask

   task automatic test_serve();
      logic [8:0] addrs [5]  = '{9'd0, 9'd255, 9'd17, 9'd17, 9'd128};
      logic [7:0] exps  [5]  = '{8'hA5, 8'h5A, 8'hB4, 8'hB4, 8'h25};
      for (int k = 0; k < 5; k++) begin
         if (k == 4) begin
            data_req = 1'b0;
            for (int j = 0; j < 2; j++) begin
               step();
               tests_run++;
               if (data_valid !== 1'b0 || data !== 8'h00) begin
                  fails++;
                  $display("FAIL serve_idle%0d: valid=%b data=%h, need 0 00", j, data_valid, data);
               end
            end
         end
         data_req = 1'b1; data_addr = addrs[k];
         step();
         tests_run++;
         if (data_valid !== 1'b1 || data !== exps[k]) begin
            fails++;
            $display("FAIL serve_addr%0d: valid=%b data=%h, need 1 %h", addrs[k], data_valid, data, exps[k]);
         end
      end
      data_req = 1'b0;
      step();
      tests_run++;
      if (data_valid !== 1'b0 || req_count !== 16'd5 || addr_err !== 1'b0) begin
         fails++;
         $display("FAIL serve_count: valid=%b cnt=%0d err=%b, need 0 5 0", data_valid, req_count, addr_err);
      end
   endtask

   task automatic test_out_of_range();
      logic [8:0] addrs [2] = '{9'd256, 9'd511};
      for (int k = 0; k < 2; k++) begin
         data_req = 1'b1; data_addr = addrs[k];
         step();
         tests_run++;
         if (data_valid !== 1'b1 || data !== 8'h00 || addr_err !== 1'b1 || req_count !== 16'(6 + k)) begin
            fails++;
            $display("FAIL oor_%0d: valid=%b data=%h err=%b cnt=%0d, need 1 00 1 %0d",
                     addrs[k], data_valid, data, addr_err, req_count, 6 + k);
         end
      end
      data_req = 1'b0; data_addr = 9'd1;
      step();
      tests_run++;
      if (addr_err !== 1'b1 || data_valid !== 1'b0) begin
         fails++;
         $display("FAIL oor_sticky: err=%b valid=%b, need 1 0", addr_err, data_valid);
      end
   endtask

   task automatic test_finish_collision();
      data_req = 1'b1; data_addr = 9'd3; finish = 1'b1;
      step();
      tests_run++;
      if (data_valid !== 1'b1 || data !== 8'hA6 || req_count !== 16'd8) begin
         fails++;
         $display("FAIL finish_collide: valid=%b data=%h cnt=%0d, need 1 a6 8", data_valid, data, req_count);
      end
      finish = 1'b0; data_addr = 9'd4;
      step();
      tests_run++;
      if (data_valid !== 1'b0 || data !== 8'h00 || req_count !== 16'd8 || load_done !== 1'b1 || addr_err !== 1'b1) begin
         fails++;
         $display("FAIL done_frozen: valid=%b data=%h cnt=%0d done=%b err=%b, need 0 00 8 1 1",
                  data_valid, data, req_count, load_done, addr_err);
      end
      data_req = 1'b0;
   endtask

   task automatic test_load_backpressure();
      int acc, bad;
      logic [8:0] addrs [5] = '{9'd0, 9'd1, 9'd2, 9'd100, 9'd255};
      reset = 1'b0;
      step();
      reset = 1'b1;
      do_load(1, 1'b1, acc, bad);
      tests_run++;
      if (acc !== 256 || bad !== 0 || req_count !== 16'd0 || load_done !== 1'b1) begin
         fails++;
         $display("FAIL bp_load: accepted=%0d anomalies=%0d cnt=%0d done=%b, need 256 0 0 1",
                  acc, bad, req_count, load_done);
      end
      // load_valid while serving must not disturb memory
      load_valid = 1'b1; load_data = 8'hEE;
      for (int k = 0; k < 5; k++) begin
         data_req = 1'b1; data_addr = addrs[k];
         step();
         tests_run++;
         if (data_valid !== 1'b1 || data !== pat(1, int'(addrs[k]))) begin
            fails++;
            $display("FAIL bp_read%0d: valid=%b data=%h, need 1 %h", addrs[k], data_valid, data, pat(1, int'(addrs[k])));
         end
      end
      load_valid = 1'b0; data_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      int acc, bad;
      data_req = 1'b1; data_addr = 9'd300;
      step();
      data_addr = 9'd5; reset = 1'b0;
      step();
      tests_run++;
      if ({load_ready, load_done, data_valid, addr_err} !== 4'b1000 || data !== 8'h00 || req_count !== 16'd0) begin
         fails++;
         $display("FAIL mid_reset: rdy/done/vld/err=%b data=%h cnt=%0d, need 1000 00 0",
                  {load_ready, load_done, data_valid, addr_err}, data, req_count);
      end
      reset = 1'b1; data_req = 1'b0;
      do_load(2, 1'b0, acc, bad);
      tests_run++;
      if (acc !== 256 || bad !== 0) begin
         fails++;
         $display("FAIL reload: accepted=%0d anomalies=%0d, need 256 0", acc, bad);
      end
      data_req = 1'b1; data_addr = 9'd7;
      step();
      tests_run++;
      if (data_valid !== 1'b1 || data !== 8'h3B) begin
         fails++;
         $display("FAIL reload_read7: valid=%b data=%h, need 1 3b", data_valid, data);
      end
      data_addr = 9'd200;
      step();
      tests_run++;
      if (data_valid !== 1'b1 || data !== 8'hF4 || req_count !== 16'd2) begin
         fails++;
         $display("FAIL reload_read200: valid=%b data=%h cnt=%0d, need 1 f4 2", data_valid, data, req_count);
      end
      data_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load();
      test_serve();
      test_out_of_range();
      test_finish_collision();
      test_load_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
